// File: rtl/desen_ctrl_pkg.sv
// desen_ctrl_pkg
//   Shared types and constants for the Desen job sequencer.
//   - desen_state_e : sequencer FSM states (3-bit encoding)
//   - DESEN_NIB_W   : width of one generator pattern nibble
//   - DESEN_SEED_W  : generator address width (seed / prev buses)
package desen_ctrl_pkg;

  localparam int DESEN_NIB_W  = 4;
  localparam int DESEN_SEED_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_RUN     = 3'd2,
    ST_STOP    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_RESULT  = 3'd5
  } desen_state_e;

endpackage

// File: rtl/desen_run_timer.sv
// desen_run_timer
//   Loadable down-counter that times the RUN phase of a Desen job.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     i_load    : load i_len (has priority over i_dec)
//     i_len     : run length to load
//     i_dec     : decrement by one; ignored when already zero
//     o_zero    : counter value is zero
module desen_run_timer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [LEN_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_len;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/desen_ctrl.sv
// desen_ctrl
//   Job sequencer for the Desen pattern generator (toggle FF + 4-bit
//   counter + LUT). Accepts {seed, run length} jobs, pulses the generator
//   toggle at start and stop, samples the frozen pattern nibble, keeps the
//   last three nibbles as history and returns each nibble on a result port.
//   Optional feature macro: DESEN_CTRL_ABORT_EN (adds the abort input).
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     req_valid/req_ready   : job request handshake (ready only in IDLE)
//     req_seed, req_len     : job seed and RUN cycle count
//     gen_start, gen_stop   : one-cycle toggle pulses to the generator
//     gen_seed, gen_prev    : registered seed and nibble history
//     gen_out               : generator LUT output
//     res_valid/res_ready   : result handshake, res_data = captured nibble
//     busy                  : any state other than IDLE
//     abort                 : (DESEN_CTRL_ABORT_EN) cut RUN short, no result
import desen_ctrl_pkg::*;

module desen_ctrl #(
  parameter int LEN_W  = 8,
  parameter int SEED_W = DESEN_SEED_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SEED_W-1:0]      req_seed,
  input  logic [LEN_W-1:0]       req_len,
  output logic                   gen_start,
  output logic                   gen_stop,
  output logic [SEED_W-1:0]      gen_seed,
  output logic [SEED_W-1:0]      gen_prev,
  input  logic [DESEN_NIB_W-1:0] gen_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DESEN_NIB_W-1:0] res_data,
`ifdef DESEN_CTRL_ABORT_EN
  input  logic                   abort,
`endif
  output logic                   busy
);

  desen_state_e            r_state;
  desen_state_e            w_state_nxt;
  logic                    w_load;
  logic                    w_dec;
  logic                    w_zero;
  logic                    w_abort_req;
  logic                    w_aborted;
  logic [SEED_W-1:0]       r_gen_seed;
  logic [SEED_W-1:0]       r_gen_prev;
  logic [DESEN_NIB_W-1:0]  r_res_data;

  desen_run_timer #(
    .LEN_W (LEN_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_len  (req_len),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );

`ifdef DESEN_CTRL_ABORT_EN
  logic r_aborted;

  assign w_abort_req = abort && (r_state == ST_RUN);

  // Remembers that the current job was aborted so CAPTURE skips the
  // history update and the result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aborted <= 1'b0;
    end else if (w_load) begin
      r_aborted <= 1'b0;
    end else if (w_abort_req) begin
      r_aborted <= 1'b1;
    end
  end

  assign w_aborted = r_aborted;
`else
  assign w_abort_req = 1'b0;
  assign w_aborted   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The timer is pre-decremented in START, so RUN ends once it reads zero
  // and lasts exactly req_len cycles (zero cycles when req_len == 0).
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_dec       = 1'b1;
        w_state_nxt = w_zero ? ST_STOP : ST_RUN;
      end
      ST_RUN: begin
        if (w_abort_req || w_zero) begin
          w_state_nxt = ST_STOP;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_STOP: begin
        w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_state_nxt = w_aborted ? ST_IDLE : ST_RESULT;
      end
      ST_RESULT: begin
        if (res_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Seed is held for the whole job; the nibble is sampled in CAPTURE,
  // when the generator counter has stopped advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gen_seed <= '0;
      r_gen_prev <= '0;
      r_res_data <= '0;
    end else begin
      if (w_load) begin
        r_gen_seed <= req_seed;
      end
      if (r_state == ST_CAPTURE) begin
        r_res_data <= gen_out;
        if (!w_aborted) begin
          r_gen_prev <= {r_gen_prev[SEED_W-DESEN_NIB_W-1:0], gen_out};
        end
      end
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign gen_start = (r_state == ST_START);
  assign gen_stop  = (r_state == ST_STOP);
  assign res_valid = (r_state == ST_RESULT);
  assign gen_seed  = r_gen_seed;
  assign gen_prev  = r_gen_prev;
  assign res_data  = r_res_data;

endmodule

// File: tb/tb_desen_ctrl.sv
module tb_desen_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_seed;
  logic [7:0]  req_len;
  logic        gen_start;
  logic        gen_stop;
  logic [11:0] gen_seed;
  logic [11:0] gen_prev;
  logic [3:0]  gen_out;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_data;
  logic        busy;
  logic        abort;

  int n_checks = 0;
  int n_errors = 0;

  // expected generator counter and history
  logic [3:0]  exp_cnt;
  logic [11:0] exp_prev;

  // generator model: toggle FF + 4-bit counter + LUT
  logic        g_ff;
  logic [3:0]  g_cnt;

  function automatic logic [3:0] lut(input logic [11:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ 4'h9;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      g_ff  <= 1'b0;
      g_cnt <= 4'd0;
    end else begin
      if (gen_start || gen_stop) g_ff <= ~g_ff;
      if (g_ff) g_cnt <= g_cnt + 4'd1;
    end
  end

  assign gen_out = lut(gen_seed + gen_prev + {8'h00, g_cnt});

  desen_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_seed  (req_seed),
    .req_len   (req_len),
    .gen_start (gen_start),
    .gen_stop  (gen_stop),
    .gen_seed  (gen_seed),
    .gen_prev  (gen_prev),
    .gen_out   (gen_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
`ifdef DESEN_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one job, track pulse timing up to res_valid, compare against the
  // model; optionally consume the result.
  task automatic do_job(input logic [11:0] seed, input logic [7:0] len,
                        input bit consume, output logic [3:0] nib);
    int t_start, t_stop, t_res, n_start, n_stop;
    bit both;
    logic [11:0] addr;
    t_start = -1; t_stop = -1; t_res = -1;
    n_start = 0; n_stop = 0; both = 1'b0;
    @(negedge clk);
    req_seed  = seed;
    req_len   = len;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= int'(len) + 20; c++) begin
      if (gen_start && gen_stop) both = 1'b1;
      if (gen_start) begin n_start++; if (t_start < 0) t_start = c; end
      if (gen_stop)  begin n_stop++;  if (t_stop < 0)  t_stop = c; end
      if (c == 1) chk("seed_latch", gen_seed, seed);
      if (res_valid) begin t_res = c; break; end
      @(posedge clk); #1;
    end
    exp_cnt  = exp_cnt + len[3:0] + 4'd1;
    addr     = seed + exp_prev + {8'h00, exp_cnt};
    nib      = lut(addr);
    exp_prev = {exp_prev[7:0], nib};
    chk("start_lat", t_start, 1);
    chk("stop_lat", t_stop, int'(len) + 2);
    chk("res_lat", t_res, int'(len) + 4);
    chk("pulse_cnt", {n_start[15:0], n_stop[15:0]}, {16'd1, 16'd1});
    chk("pulse_overlap", both, 0);
    chk("res_data", res_data, nib);
    chk("gen_prev", gen_prev, exp_prev);
    chk("gen_cnt", g_cnt, exp_cnt);
    chk("seed_hold", gen_seed, seed);
    if (consume) begin
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("idle_after", {req_ready, busy, res_valid}, 3'b100);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_ctrl", {req_ready, busy, res_valid, gen_start, gen_stop}, 5'b10000);
    chk("rst_data", {gen_seed, gen_prev, res_data}, 28'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt  = 4'd0;
    exp_prev = 12'h000;
  endtask

  initial begin : main
    logic [3:0] a, b, c, d, n;
    logic [3:0] held;
    bit   vld_ok, data_ok, accepted, stop_seen;
    rst = 1'b1; req_valid = 1'b0; req_seed = '0; req_len = '0;
    res_ready = 1'b0; abort = 1'b0;
    exp_cnt = 4'd0; exp_prev = 12'h000;

    // reset
    do_reset();

    // res_ready before any result has no effect
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("early_ready", {res_valid, busy, req_ready}, 3'b001);
    @(negedge clk); res_ready = 1'b0;

    // single job seed 0x010 len 3: addr 0x014 -> 4^1^0^9 = C
    do_job(12'h010, 8'd3, 1'b1, n);
    chk("job1_lit", res_data, 4'hC);

    // len=0 job: addr 0x100+0x00C+5 = 0x111 -> 1^1^1^9 = 8
    do_job(12'h100, 8'd0, 1'b1, n);
    chk("job2_lit", res_data, 4'h8);

    // history: A,B,C then D (last address wraps past 0xFFF)
    do_reset();
    do_job(12'h234, 8'd2, 1'b1, a);
    do_job(12'h3A0, 8'd5, 1'b1, b);
    do_job(12'hFFE, 8'd7, 1'b1, c);
    chk("hist3", gen_prev, {a, b, c});
    do_job(12'h5C3, 8'd1, 1'b1, d);
    chk("hist4", gen_prev, {b, c, d});

    // backpressure with an ignored request
    do_job(12'h0F0, 8'd4, 1'b0, n);
    held = res_data;
    vld_ok = 1'b1; data_ok = 1'b1; accepted = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = (i == 3);
      req_seed  = 12'hABC;
      req_len   = 8'd2;
      @(posedge clk); #1;
      if (!res_valid) vld_ok = 1'b0;
      if (res_data !== held) data_ok = 1'b0;
      if (gen_start) accepted = 1'b1;
    end
    @(negedge clk); req_valid = 1'b0;
    chk("bp_valid", vld_ok, 1);
    chk("bp_data", data_ok, 1);
    chk("bp_noaccept", {accepted, gen_seed}, {1'b0, 12'h0F0});
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp_idle", {busy, req_ready, gen_start}, 3'b010);

    // reset while in RUN
    @(negedge clk);
    req_seed = 12'h777; req_len = 8'd10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("in_run", {busy, gen_start, gen_stop}, 3'b100);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_run_ctrl", {req_ready, busy, gen_stop, res_valid}, 4'b1000);
    chk("rst_run_prev", gen_prev, 12'h000);
    @(negedge clk); rst = 1'b0;
    exp_cnt = 4'd0; exp_prev = 12'h000;
    stop_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (gen_stop || gen_start) stop_seen = 1'b1;
    end
    chk("rst_run_nopulse", stop_seen, 0);
    do_job(12'h010, 8'd3, 1'b1, n);
    chk("post_rst_lit", res_data, 4'hC);

`ifdef DESEN_CTRL_ABORT_EN
    // abort in RUN with len=200
    begin : abort_test
      logic [11:0] prev_before;
      bit vld_seen;
      prev_before = gen_prev;
      vld_seen = 1'b0;
      @(negedge clk);
      req_seed = 12'h055; req_len = 8'd200; req_valid = 1'b1;
      @(posedge clk); #1;            // cycle 1: START
      req_valid = 1'b0;
      @(posedge clk); #1;            // cycle 2
      @(posedge clk); #1;            // cycle 3
      @(posedge clk); #1;            // cycle 4: RUN
      @(negedge clk); abort = 1'b1;
      @(posedge clk); #1;            // cycle 5
      abort = 1'b0;
      chk("abort_stop", gen_stop, 1);
      for (int i = 0; i < 2; i++) begin
        @(posedge clk); #1;
        if (res_valid) vld_seen = 1'b1;
      end
      chk("abort_novalid", vld_seen, 0);
      chk("abort_idle", {req_ready, busy}, 2'b10);
      chk("abort_prev", gen_prev, prev_before);
      exp_cnt = exp_cnt + 4'd4;      // FF high cycles 2..5
      chk("abort_cnt", g_cnt, exp_cnt);
      do_job(12'h321, 8'd2, 1'b1, n);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
